ram_loader: RTL and testbench

Boot-time loader sitting directly upstream of the 2048-word RAM. It consumes a byte stream from the boot interface (UART/SPI receiver) and parses it as a length-prefixed, checksummed image. It assembles big-endian 16-bit words and drives the RAM's `address`/`in`/`load` write port, one word per write. While loading it holds the CPU in reset and asserts `busy`; when loading finishes it reports `done` or `error`.

---
 rtl/ram_loader.sv | 160 ++++++++++++++++
 tb/tb_ram_loader.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/ram_loader.sv
// Boot-time RAM loader: parses a length-prefixed, XOR-checksummed byte stream,
// assembles big-endian 16-bit words and writes them to consecutive RAM
// addresses starting at BASE. Holds the CPU in reset while loading and after
// a failed load.
module ram_loader #(
    parameter logic [15:0] BASE  = 16'd0,
    parameter int          DEPTH = 2048
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic [15:0] ram_address,
    output logic [15:0] ram_in,
    output logic        ram_load,
    output logic        busy,
    output logic        cpu_reset,
    output logic        done,
    output logic        error,
    output logic [15:0] words
);

    // Handshake: a byte is consumed on any rising edge where rx_valid is high
    // and the FSM is in a byte-accepting state; there is no backpressure.

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CHECK, S_DONE, S_ERROR
    } state_t;

    localparam logic [16:0] DEPTH_W = 17'(DEPTH);

    state_t      state_q, state_d;
    logic [7:0]  len_hi_q, len_hi_d;
    logic [15:0] len_q, len_d;
    logic [7:0]  data_hi_q, data_hi_d;
    logic [7:0]  xor_q, xor_d;
    logic [15:0] words_q, words_d;
    logic [15:0] ram_address_q, ram_address_d;
    logic [15:0] ram_in_q, ram_in_d;
    logic        ram_load_q, ram_load_d;
    logic        busy_q, busy_d;
    logic        cpu_reset_q, cpu_reset_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic [15:0] rx_len;

    assign rx_len = {len_hi_q, rx_data};

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d       = state_q;
        len_hi_d      = len_hi_q;
        len_d         = len_q;
        data_hi_d     = data_hi_q;
        xor_d         = xor_q;
        words_d       = words_q;
        ram_address_d = ram_address_q;
        ram_in_d      = ram_in_q;
        ram_load_d    = 1'b0;
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                // A byte arriving with start is not taken as the length high byte.
                if (start) begin
                    state_d = S_LEN_HI;
                    words_d = 16'd0;
                    xor_d   = 8'd0;
                end
            end
            S_LEN_HI: begin
                if (rx_valid) begin
                    len_hi_d = rx_data;
                    state_d  = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (rx_valid) begin
                    len_d = rx_len;
                    if ({1'b0, rx_len} > DEPTH_W) begin
                        state_d = S_ERROR;
                    end else if (rx_len == 16'd0) begin
                        state_d = S_CHECK;
                    end else begin
                        state_d = S_DATA_HI;
                    end
                end
            end
            S_DATA_HI: begin
                if (rx_valid) begin
                    data_hi_d = rx_data;
                    xor_d     = xor_q ^ rx_data;
                    state_d   = S_DATA_LO;
                end
            end
            S_DATA_LO: begin
                if (rx_valid) begin
                    ram_address_d = BASE + words_q;
                    ram_in_d      = {data_hi_q, rx_data};
                    ram_load_d    = 1'b1;
                    words_d       = words_q + 16'd1;
                    xor_d         = xor_q ^ rx_data;
                    state_d       = (words_d == len_q) ? S_CHECK : S_DATA_HI;
                end
            end
            S_CHECK: begin
                if (rx_valid) begin
                    state_d = (rx_data == xor_q) ? S_DONE : S_ERROR;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d      = !(state_d == S_IDLE || state_d == S_DONE || state_d == S_ERROR);
        cpu_reset_d = busy_d || (state_d == S_ERROR);
        done_d      = (state_d == S_DONE);
        error_d     = (state_d == S_ERROR);
    end

    // State and output registers; CPU stays in reset while the loader is reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            len_hi_q      <= 8'd0;
            len_q         <= 16'd0;
            data_hi_q     <= 8'd0;
            xor_q         <= 8'd0;
            words_q       <= 16'd0;
            ram_address_q <= BASE;
            ram_in_q      <= 16'd0;
            ram_load_q    <= 1'b0;
            busy_q        <= 1'b0;
            cpu_reset_q   <= 1'b1;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            len_hi_q      <= len_hi_d;
            len_q         <= len_d;
            data_hi_q     <= data_hi_d;
            xor_q         <= xor_d;
            words_q       <= words_d;
            ram_address_q <= ram_address_d;
            ram_in_q      <= ram_in_d;
            ram_load_q    <= ram_load_d;
            busy_q        <= busy_d;
            cpu_reset_q   <= cpu_reset_d;
            done_q        <= done_d;
            error_q       <= error_d;
        end
    end

    assign ram_address = ram_address_q;
    assign ram_in      = ram_in_q;
    assign ram_load    = ram_load_q;
    assign busy        = busy_q;
    assign cpu_reset   = cpu_reset_q;
    assign done        = done_q;
    assign error       = error_q;
    assign words       = words_q;

endmodule

// File: tb/tb_ram_loader.sv
// Bench for ram_loader: two instances (BASE 0 and BASE 0x0100) share one
// stimulus stream; each has its own expected-write queue.
module tb_ram_loader;

  localparam logic [15:0] BASE0 = 16'h0000;
  localparam logic [15:0] BASE1 = 16'h0100;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        rx_valid;
  logic [7:0]  rx_data;

  logic [15:0] ram_address0, ram_in0, words0;
  logic        ram_load0, busy0, cpu_reset0, done0, error0;
  logic [15:0] ram_address1, ram_in1, words1;
  logic        ram_load1, busy1, cpu_reset1, done1, error1;

  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];

  int n_checks = 0;
  int n_pass   = 0;
  logic        gaps_en = 1'b0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  ram_loader #(.BASE(BASE0), .DEPTH(2048)) dut0 (
    .clk(clk), .reset(reset), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
    .ram_address(ram_address0), .ram_in(ram_in0), .ram_load(ram_load0),
    .busy(busy0), .cpu_reset(cpu_reset0), .done(done0), .error(error0), .words(words0)
  );

  ram_loader #(.BASE(BASE1), .DEPTH(2048)) dut1 (
    .clk(clk), .reset(reset), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
    .ram_address(ram_address1), .ram_in(ram_in1), .ram_load(ram_load1),
    .busy(busy1), .cpu_reset(cpu_reset1), .done(done1), .error(error1), .words(words1)
  );

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    if (gaps_en) repeat ($urandom_range(0, 3)) tick();
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
    rx_data  = $urandom_range(0, 255);
  endtask

  task automatic send_word(input logic [15:0] w, input int idx);
    exp_q0.push_back({BASE0 + 16'(idx), w});
    exp_q1.push_back({BASE1 + 16'(idx), w});
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // ---------------- scoreboards ----------------
  always @(negedge clk) begin
    if (ram_load0) begin
      if (exp_q0.size() == 0) check("wr0_unexpected_q_size", 32'(exp_q0.size()), 32'd1);
      else check("wr0_addr_data", {ram_address0, ram_in0}, exp_q0.pop_front());
    end
  end

  always @(negedge clk) begin
    if (ram_load1) begin
      if (exp_q1.size() == 0) check("wr1_unexpected_q_size", 32'(exp_q1.size()), 32'd1);
      else check("wr1_addr_data", {ram_address1, ram_in1}, exp_q1.pop_front());
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) tick();
    check("rst_addr0", 32'(ram_address0), 32'h0000);
    check("rst_addr1", 32'(ram_address1), 32'h0100);
    check("rst_in", 32'(ram_in0), 32'd0);
    check("rst_load", 32'(ram_load0), 32'd0);
    check("rst_flags", {busy0, done0, error0}, 32'd0);
    check("rst_words", 32'(words0), 32'd0);
    check("rst_cpu_reset", 32'(cpu_reset0), 32'd1);
    reset = 1'b0;
    tick();
    check("idle_cpu_reset", 32'(cpu_reset0), 32'd0);

    // Basic load
    pulse_start();
    check("basic_busy", 32'(busy0), 32'd1);
    check("basic_cpu_reset_busy", 32'(cpu_reset0), 32'd1);
    send_byte(8'h00); send_byte(8'h02);
    send_word(16'h1234, 0);
    send_word(16'hABCD, 1);
    send_byte(8'h40);
    check("basic_done", 32'(done0), 32'd1);
    check("basic_error", 32'(error0), 32'd0);
    check("basic_words", 32'(words0), 32'd2);
    check("basic_cpu_reset", 32'(cpu_reset0), 32'd0);
    check("basic_busy_end", 32'(busy0), 32'd0);
    check("basic_done1", 32'(done1), 32'd1);

    // Bad checksum
    pulse_start();
    send_byte(8'h00); send_byte(8'h02);
    send_word(16'h1234, 0);
    send_word(16'hABCD, 1);
    send_byte(8'h41);
    check("badck_error", 32'(error0), 32'd1);
    check("badck_done", 32'(done0), 32'd0);
    check("badck_cpu_reset", 32'(cpu_reset0), 32'd1);
    check("badck_words", 32'(words0), 32'd2);
    tick();
    check("badck_cpu_reset_hold", 32'(cpu_reset0), 32'd1);

    // Oversize image
    pulse_start();
    send_byte(8'h08);
    check("over_no_error_yet", 32'(error0), 32'd0);
    send_byte(8'h01);
    check("over_error", 32'(error0), 32'd1);
    check("over_words", 32'(words0), 32'd0);
    repeat (4) tick();
    check("over_no_load", 32'(ram_load0), 32'd0);

    // Empty image with random gaps
    gaps_en = 1'b1;
    pulse_start();
    send_byte(8'h00); send_byte(8'h00);
    check("empty_busy", 32'(busy0), 32'd1);
    send_byte(8'h00);
    check("empty_done", 32'(done0), 32'd1);
    check("empty_words", 32'(words0), 32'd0);
    gaps_en = 1'b0;

    // Reset in the middle of a 4-word image
    pulse_start();
    send_byte(8'h00); send_byte(8'h04);
    send_word(16'h1122, 0);
    reset = 1'b1;
    tick();
    check("midrst_busy", 32'(busy0), 32'd0);
    check("midrst_load", 32'(ram_load0), 32'd0);
    check("midrst_done", 32'(done0), 32'd0);
    reset = 1'b0;
    send_byte(8'h33); send_byte(8'h44); send_byte(8'h55);
    check("midrst_idle_busy", 32'(busy0), 32'd0);
    check("midrst_idle_words", 32'(words0), 32'd0);

    // start with a byte in the same cycle: byte must not count as length
    start = 1'b1; rx_valid = 1'b1; rx_data = 8'hFF;
    tick();
    start = 1'b0; rx_valid = 1'b0;
    send_byte(8'h00); send_byte(8'h01);
    check("samecyc_busy", 32'(busy0), 32'd1);
    send_word(16'hBEEF, 0);
    send_byte(8'h51);
    check("reload_done", 32'(done0), 32'd1);
    check("reload_words", 32'(words0), 32'd1);

    // Restart after DONE, 3 words with gaps
    gaps_en = 1'b1;
    pulse_start();
    check("restart_words_clear", 32'(words0), 32'd0);
    send_byte(8'h00); send_byte(8'h03);
    send_word(16'h0001, 0);
    send_word(16'h0203, 1);
    check("restart_words_mid", 32'(words1), 32'd2);
    send_word(16'h0405, 2);
    send_byte(8'h01);
    check("restart_done0", 32'(done0), 32'd1);
    check("restart_done1", 32'(done1), 32'd1);
    check("restart_words", 32'(words1), 32'd3);
    gaps_en = 1'b0;

    repeat (3) tick();
    check("q0_drained", 32'(exp_q0.size()), 32'd0);
    check("q1_drained", 32'(exp_q1.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
